// File: rtl/sr_flag_arbiter.sv
// Two-requester arbiter/sequencer driving timed active-low SET_B/RESET_B strobes into a
// flag bank, with a shadow copy of the flags. Define SR_FLAG_ARB_FIXED_PRIO_EN for fixed A-over-B priority.
module sr_flag_arbiter #(
  parameter int NFLAGS    = 8,
  parameter int IDXW      = 3,
  parameter int PULSE_LEN = 2
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              A_VALID,
  output logic              A_READY,
  input  logic [1:0]        A_OP,
  input  logic [IDXW-1:0]   A_IDX,
  input  logic              B_VALID,
  output logic              B_READY,
  input  logic [1:0]        B_OP,
  input  logic [IDXW-1:0]   B_IDX,
  output logic [NFLAGS-1:0] SET_B,
  output logic [NFLAGS-1:0] RESET_B,
  output logic [NFLAGS-1:0] FLAGS,
  output logic              BUSY,
  output logic              DONE,
  output logic              DONE_SRC,
  output logic              DONE_ERR,
  output logic              DONE_VAL
);

  localparam int CNTW = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
  localparam logic [CNTW-1:0] CNT_LOAD = CNTW'(PULSE_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Handshake: a command transfers on a cycle where VALID and READY are both high. READY is
  // a combinational grant raised only in IDLE; requesters hold VALID/OP/IDX stable until then.
  state_t            state;
  logic [CNTW-1:0]   cnt;
  logic [IDXW-1:0]   idx_q;
  logic              src_q;
  logic              err_q;
  logic [NFLAGS-1:0] set_b_q;
  logic [NFLAGS-1:0] reset_b_q;
  logic [NFLAGS-1:0] flags_q;
  logic              done_q;
  logic              done_src_q;
  logic              done_err_q;
  logic              done_val_q;

  logic              prefer_a;
  logic              in_idle;
  logic              grant_a;
  logic              grant_b;
  logic [1:0]        sel_op;
  logic [IDXW-1:0]   sel_idx;
  logic              sel_err;
  logic              sel_flag;
  logic [NFLAGS-1:0] sel_hot;
  logic              do_set;
  logic              do_rst;
  logic [NFLAGS-1:0] flags_nxt;
  logic              nxt_val;

`ifdef SR_FLAG_ARB_FIXED_PRIO_EN
  assign prefer_a = 1'b1;
`else
  // Remembers whether B was served last; resets high so A wins the first tie.
  logic last_b;
  assign prefer_a = last_b;
`endif

  always_comb begin
    in_idle  = (state == ST_IDLE) && !RESET;
    grant_a  = in_idle && A_VALID && (!B_VALID || prefer_a);
    grant_b  = in_idle && B_VALID && (!A_VALID || !prefer_a);
    sel_op   = grant_b ? B_OP : A_OP;
    sel_idx  = grant_b ? B_IDX : A_IDX;
    sel_err  = int'(sel_idx) >= NFLAGS;
    sel_hot  = '0;
    sel_flag = 1'b0;
    for (int i = 0; i < NFLAGS; i++) begin
      if (int'(sel_idx) == i) begin
        sel_hot[i] = 1'b1;
        sel_flag   = flags_q[i];
      end
    end
    // Toggle direction is fixed by the flag value seen at accept time.
    do_set = !sel_err && ((sel_op == 2'b01) || ((sel_op == 2'b11) && !sel_flag));
    do_rst = !sel_err && ((sel_op == 2'b10) || ((sel_op == 2'b11) && sel_flag));
    // The held strobes double as the update masks for the shadow flags.
    flags_nxt = (flags_q | ~set_b_q) & reset_b_q;
    nxt_val   = 1'b0;
    for (int i = 0; i < NFLAGS; i++) begin
      if (int'(idx_q) == i) nxt_val = flags_nxt[i];
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      idx_q      <= '0;
      src_q      <= 1'b0;
      err_q      <= 1'b0;
      set_b_q    <= '1;
      reset_b_q  <= '1;
      flags_q    <= '0;
      done_q     <= 1'b0;
      done_src_q <= 1'b0;
      done_err_q <= 1'b0;
      done_val_q <= 1'b0;
`ifndef SR_FLAG_ARB_FIXED_PRIO_EN
      last_b     <= 1'b1;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_a || grant_b) begin
            src_q     <= grant_b;
            idx_q     <= sel_idx;
            err_q     <= sel_err;
            cnt       <= CNT_LOAD;
            set_b_q   <= do_set ? ~sel_hot : '1;
            reset_b_q <= do_rst ? ~sel_hot : '1;
            state     <= ST_PULSE;
          end
        end
        ST_PULSE: begin
          if (cnt == '0) begin
            set_b_q    <= '1;
            reset_b_q  <= '1;
            flags_q    <= flags_nxt;
            done_q     <= 1'b1;
            done_src_q <= src_q;
            done_err_q <= err_q;
            done_val_q <= !err_q && nxt_val;
`ifndef SR_FLAG_ARB_FIXED_PRIO_EN
            last_b     <= src_q;
`endif
            state      <= ST_DONE;
          end else begin
            cnt <= cnt - CNTW'(1);
          end
        end
        ST_DONE: begin
          done_q <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign A_READY  = grant_a;
  assign B_READY  = grant_b;
  assign SET_B    = set_b_q;
  assign RESET_B  = reset_b_q;
  assign FLAGS    = flags_q;
  assign BUSY     = (state != ST_IDLE);
  assign DONE     = done_q;
  assign DONE_SRC = done_src_q;
  assign DONE_ERR = done_err_q;
  assign DONE_VAL = done_val_q;

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// Bench for sr_flag_arbiter: an 8-flag and a 6-flag instance share the same requester inputs
// and are checked against a transaction-level flag model.
module tb_sr_flag_arbiter;

  localparam int PL = 2;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       A_VALID = 1'b0, B_VALID = 1'b0;
  logic [1:0] A_OP = '0, B_OP = '0;
  logic [2:0] A_IDX = '0, B_IDX = '0;

  logic       a_rdy8, b_rdy8, busy8, done8, dsrc8, derr8, dval8;
  logic [7:0] setb8, rstb8, flags8;
  logic       a_rdy6, b_rdy6, busy6, done6, dsrc6, derr6, dval6;
  logic [5:0] setb6, rstb6, flags6;

  int n_cmp = 0;
  int n_err = 0;

  // model state
  logic [7:0] m_fl8 = '0;
  logic [5:0] m_fl6 = '0;
  logic       m_last_b = 1'b1;

  always #5 CLK = ~CLK;

  sr_flag_arbiter #(.NFLAGS(8), .IDXW(3), .PULSE_LEN(PL)) u8 (
    .CLK(CLK), .RESET(RESET),
    .A_VALID(A_VALID), .A_READY(a_rdy8), .A_OP(A_OP), .A_IDX(A_IDX),
    .B_VALID(B_VALID), .B_READY(b_rdy8), .B_OP(B_OP), .B_IDX(B_IDX),
    .SET_B(setb8), .RESET_B(rstb8), .FLAGS(flags8), .BUSY(busy8),
    .DONE(done8), .DONE_SRC(dsrc8), .DONE_ERR(derr8), .DONE_VAL(dval8)
  );

  sr_flag_arbiter #(.NFLAGS(6), .IDXW(3), .PULSE_LEN(PL)) u6 (
    .CLK(CLK), .RESET(RESET),
    .A_VALID(A_VALID), .A_READY(a_rdy6), .A_OP(A_OP), .A_IDX(A_IDX),
    .B_VALID(B_VALID), .B_READY(b_rdy6), .B_OP(B_OP), .B_IDX(B_IDX),
    .SET_B(setb6), .RESET_B(rstb6), .FLAGS(flags6), .BUSY(busy6),
    .DONE(done6), .DONE_SRC(dsrc6), .DONE_ERR(derr6), .DONE_VAL(dval6)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Outcome of one command on an n-flag bank, straight from the command semantics.
  function automatic void model(input int n, input logic [7:0] fl, input logic [1:0] op,
                                input int idx, output logic [7:0] sb, output logic [7:0] rb,
                                output logic [7:0] nf, output logic err, output logic val);
    sb  = 8'hFF;
    rb  = 8'hFF;
    nf  = fl;
    err = (idx >= n);
    val = 1'b0;
    if (!err) begin
      case (op)
        2'b01: begin sb[idx] = 1'b0; nf[idx] = 1'b1; end
        2'b10: begin rb[idx] = 1'b0; nf[idx] = 1'b0; end
        2'b11: begin
          if (fl[idx]) begin rb[idx] = 1'b0; nf[idx] = 1'b0; end
          else begin sb[idx] = 1'b0; nf[idx] = 1'b1; end
        end
        default: ;
      endcase
      val = nf[idx];
    end
  endfunction

  // Called at a negedge with both DUTs idle; returns at the first idle negedge after DONE.
  task automatic issue(input logic av, input logic [1:0] aop, input logic [2:0] aidx,
                       input logic bv, input logic [1:0] bop, input logic [2:0] bidx,
                       output logic won_b);
    logic pa, ea, eb;
    logic [1:0] op;
    int idx;
    logic [7:0] sb8, rb8, nf8, sb6, rb6, nf6;
    logic er8, v8, er6, v6;
    A_VALID = av; A_OP = aop; A_IDX = aidx;
    B_VALID = bv; B_OP = bop; B_IDX = bidx;
    #1;
`ifdef SR_FLAG_ARB_FIXED_PRIO_EN
    pa = 1'b1;
`else
    pa = m_last_b;
`endif
    ea = av && (!bv || pa);
    eb = bv && (!av || !pa);
    won_b = eb;
    chk("a_ready8", a_rdy8, ea);
    chk("b_ready8", b_rdy8, eb);
    chk("a_ready6", a_rdy6, ea);
    chk("b_ready6", b_rdy6, eb);
    if (!ea && !eb) begin
      @(negedge CLK);
      chk("idle_busy8", busy8, 1'b0);
      return;
    end
    op  = eb ? bop : aop;
    idx = eb ? int'(bidx) : int'(aidx);
    model(8, m_fl8, op, idx, sb8, rb8, nf8, er8, v8);
    model(6, {2'b00, m_fl6}, op, idx, sb6, rb6, nf6, er6, v6);
    @(negedge CLK);
    if (eb) begin B_VALID = 1'b0; B_OP = 2'($urandom); B_IDX = 3'($urandom); end
    else begin A_VALID = 1'b0; A_OP = 2'($urandom); A_IDX = 3'($urandom); end
    for (int k = 0; k < PL; k++) begin
      chk("pulse_set_b8", setb8, sb8);
      chk("pulse_reset_b8", rstb8, rb8);
      chk("pulse_set_b6", setb6, sb6[5:0]);
      chk("pulse_reset_b6", rstb6, rb6[5:0]);
      chk("pulse_busy8", busy8, 1'b1);
      chk("pulse_done8", done8, 1'b0);
      chk("pulse_done6", done6, 1'b0);
      @(negedge CLK);
    end
    chk("done8", done8, 1'b1);
    chk("done6", done6, 1'b1);
    chk("done_src8", dsrc8, eb);
    chk("done_src6", dsrc6, eb);
    chk("done_err8", derr8, er8);
    chk("done_err6", derr6, er6);
    chk("done_val8", dval8, v8);
    chk("done_val6", dval6, v6);
    chk("flags8", flags8, nf8);
    chk("flags6", flags6, nf6[5:0]);
    chk("done_set_b8", setb8, 8'hFF);
    chk("done_reset_b8", rstb8, 8'hFF);
    chk("done_set_b6", setb6, 6'h3F);
    m_fl8 = nf8;
    m_fl6 = nf6[5:0];
    m_last_b = eb;
    @(negedge CLK);
    chk("post_busy8", busy8, 1'b0);
    chk("post_done8", done8, 1'b0);
  endtask

  initial begin
    logic wb, av, bv, pa, pb;
    logic [1:0] aop, bop;
    logic [2:0] aidx, bidx;

    // reset: READY stays low even with a valid request
    A_VALID = 1'b1; A_OP = 2'b01;
    repeat (2) @(negedge CLK);
    chk("rst_a_ready8", a_rdy8, 1'b0);
    chk("rst_set_b8", setb8, 8'hFF);
    chk("rst_reset_b8", rstb8, 8'hFF);
    chk("rst_flags8", flags8, 8'h00);
    chk("rst_busy8", busy8, 1'b0);
    chk("rst_done8", {done8, dsrc8, derr8, dval8}, 4'b0000);
    chk("rst_set_b6", setb6, 6'h3F);
    A_VALID = 1'b0;
    RESET = 1'b0;
    @(negedge CLK);

    // set idx 3, then contended clear 3 / set 5, then contended again
    issue(1, 2'b01, 3'd3, 0, 2'b00, 3'd0, wb);
    issue(1, 2'b10, 3'd3, 1, 2'b01, 3'd5, wb);
    if (wb) issue(1, 2'b10, 3'd3, 0, 2'b00, 3'd0, wb);
    else issue(0, 2'b00, 3'd0, 1, 2'b01, 3'd5, wb);
    issue(1, 2'b01, 3'd1, 1, 2'b01, 3'd2, wb);
    if (wb) issue(1, 2'b01, 3'd1, 0, 2'b00, 3'd0, wb);
    else issue(0, 2'b00, 3'd0, 1, 2'b01, 3'd2, wb);

    // toggles, redundant set, out-of-range on the 6-flag bank, queries
    issue(1, 2'b11, 3'd0, 0, 2'b00, 3'd0, wb);
    issue(0, 2'b00, 3'd0, 1, 2'b11, 3'd0, wb);
    issue(1, 2'b01, 3'd3, 0, 2'b00, 3'd0, wb);
    issue(1, 2'b01, 3'd3, 0, 2'b00, 3'd0, wb);
    issue(1, 2'b00, 3'd3, 0, 2'b00, 3'd0, wb);
    issue(1, 2'b01, 3'd7, 0, 2'b00, 3'd0, wb);
    issue(0, 2'b00, 3'd0, 1, 2'b01, 3'd6, wb);
    issue(1, 2'b00, 3'd7, 0, 2'b00, 3'd0, wb);
    issue(0, 2'b00, 3'd0, 0, 2'b00, 3'd0, wb);

    // reset in the middle of a pulse
    A_VALID = 1'b1; A_OP = 2'b01; A_IDX = 3'd4;
    @(negedge CLK);
    A_VALID = 1'b0;
    chk("mid_set_b8", setb8, 8'hEF);
    #2 RESET = 1'b1;
    #1;
    chk("mid_rst_set_b8", setb8, 8'hFF);
    chk("mid_rst_busy8", busy8, 1'b0);
    chk("mid_rst_flags8", flags8, 8'h00);
    chk("mid_rst_flags6", flags6, 6'h00);
    @(negedge CLK);
    RESET = 1'b0;
    m_fl8 = '0; m_fl6 = '0; m_last_b = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("mid_rst_no_done8", done8, 1'b0);
      @(negedge CLK);
    end

    // A held valid continuously against a waiting B
    for (int k = 0; k < 4; k++) begin
      issue(1, 2'($urandom), 3'($urandom), 1, 2'b01, 3'd2, wb);
      if (wb) break;
    end
    if (B_VALID) issue(0, 2'b00, 3'd0, 1, 2'b01, 3'd2, wb);

    // randomized traffic; a losing requester keeps its command until served
    pa = 1'b0; pb = 1'b0;
    aop = '0; bop = '0; aidx = '0; bidx = '0;
    for (int it = 0; it < 60; it++) begin
      if (pa) av = 1'b1;
      else begin av = 1'($urandom_range(0, 1)); aop = 2'($urandom); aidx = 3'($urandom); end
      if (pb) bv = 1'b1;
      else begin bv = 1'($urandom_range(0, 1)); bop = 2'($urandom); bidx = 3'($urandom); end
      issue(av, aop, aidx, bv, bop, bidx, wb);
      if (!av && !bv) begin pa = 1'b0; pb = 1'b0; end
      else if (wb) begin pb = 1'b0; pa = av; end
      else begin pa = 1'b0; pb = bv; end
    end
    while (pa || pb) begin
      issue(pa, aop, aidx, pb, bop, bidx, wb);
      if (wb) pb = 1'b0; else pa = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sr_flag_arbiter.md
Name: sr_flag_arbiter

Overview:
Sequencer and arbiter for a bank of NFLAGS set/reset flag flops with active-low SET_B/RESET_B strobes. Two requesters (A, B) issue set, clear, toggle or query commands over valid/ready handshakes. The block arbitrates between them, generates timed active-low strobe pulses for the addressed bit, and keeps a shadow copy of the flag state. It never drives both strobes low on the same bit.

Parameters:
NFLAGS, 8, number of flags in the bank (1..256)
IDXW, 3, width of the flag index fields (2**IDXW >= NFLAGS)
PULSE_LEN, 2, cycles each strobe is held low (>=1)

Ports:
CLK  input  1  clock, all logic on rising edge
RESET  input  1  asynchronous active-high reset
A_VALID  input  1  requester A command valid
A_READY  output  1  requester A command accepted this cycle
A_OP  input  2  01 set, 10 clear, 11 toggle, 00 query
A_IDX  input  IDXW  flag index for A
B_VALID  input  1  requester B command valid
B_READY  output  1  requester B command accepted this cycle
B_OP  input  2  as A_OP
B_IDX  input  IDXW  as A_IDX
SET_B  output  NFLAGS  active-low set strobes to flag bank
RESET_B  output  NFLAGS  active-low reset strobes to flag bank
FLAGS  output  NFLAGS  shadow flag state
BUSY  output  1  high when FSM is not in IDLE
DONE  output  1  one-cycle completion pulse
DONE_SRC  output  1  requester of the completed command (0 = A, 1 = B)
DONE_ERR  output  1  qualifies DONE; index was out of range
DONE_VAL  output  1  qualifies DONE; FLAGS[idx] after the operation (0 on error)

Behaviour:
- Reset (async, immediate):
  - FLAGS = 0; SET_B and RESET_B all ones.
  - A_READY, B_READY, BUSY, DONE, DONE_SRC, DONE_ERR, DONE_VAL = 0.
  - Round-robin pointer set so that A wins the first tie.
  - An in-flight command is dropped and no DONE is issued for it.
- FSM states: IDLE, PULSE, DONE.
- IDLE:
  - READY is combinational grant, asserted only in IDLE.
  - Only one valid requester: it is granted.
  - Both valid: grant the requester not served last.
  - On VALID&READY, register op, idx and source, load counter = PULSE_LEN-1, go to PULSE.
  - The requester must hold VALID/OP/IDX stable until READY.
- PULSE:
  - Set: SET_B[idx] = 0.
  - Clear: RESET_B[idx] = 0.
  - Toggle: direction decided from FLAGS[idx] at accept time (1 gives RESET_B strobe, 0 gives SET_B strobe).
  - Query or idx >= NFLAGS: no strobe.
  - All other strobe bits stay 1.
  - Strobes are registered outputs, held for exactly PULSE_LEN cycles.
  - Counter 0 -> DONE.
- DONE (one cycle):
  - All strobes are 1.
  - FLAGS[idx] is updated on entry.
  - DONE = 1 with DONE_SRC, DONE_ERR, DONE_VAL.
  - Round-robin pointer updated. Next state IDLE.
- Latency: accept at cycle T; strobe low T+1..T+PULSE_LEN; DONE at T+PULSE_LEN+1; earliest next accept T+PULSE_LEN+2.
- Redundant commands: set on a flag already 1 (or clear on 0) still strobes and completes normally.
- Invariant: for every bit, SET_B and RESET_B are never both 0. At most one strobe bit is low in any cycle.
- Unused OP/IDX bits while VALID is low are ignored.

Optional Feature:
SR_FLAG_ARB_FIXED_PRIO_EN
- Defined: A always wins when both requesters are valid; the round-robin pointer is removed. B can starve.
- Undefined: round-robin arbitration as above.

Test Plan:
- Reset then A set idx 3 (PULSE_LEN=2) -> A_READY at T; SET_B = 8'hF7 at T+1, T+2; DONE at T+3 with SRC=0, VAL=1; FLAGS = 8'h08.
- A and B both valid in IDLE with clear idx 3 and set idx 5 -> A served first. B accepted at T+4 with RESET_B unchanged and SET_B = 8'hDF. Then both valid again -> A served (B was last).
- Toggle idx 0 twice from FLAGS = 0 -> first gives a SET_B[0] pulse and VAL=1; second gives a RESET_B[0] pulse and VAL=0; FLAGS[0] = 0.
- NFLAGS=6, IDXW=3, set idx 7 -> no strobe for 2 cycles, DONE with ERR=1, FLAGS unchanged.
- RESET asserted mid-PULSE -> strobes return to all ones the same cycle, no DONE, FLAGS = 0, BUSY = 0.
- Query idx 3 with FLAGS = 8'h08 -> no strobe, DONE with VAL=1. With SR_FLAG_ARB_FIXED_PRIO_EN, A held valid continuously -> B never granted.
